// File: rtl/tff_load_counter_pkg.sv
// rtl/tff_load_counter_pkg.sv - shared counter mode encodings and width default
package tff_load_counter_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/tff_load_counter_if.sv
// rtl/tff_load_counter_if.sv - control and status bundle for the T-flop load counter
import tff_load_counter_pkg::*;

interface tff_load_counter_if #(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             tc;
  logic             wrap;

  modport master (output mode, output d, input q, input qb, input tc, input wrap);
  modport slave  (input mode, input d, output q, output qb, output tc, output wrap);
endinterface

// File: rtl/tff_load_counter_cell.sv
// rtl/tff_load_counter_cell.sv - single-bit T flip-flop with synchronous active-low reset
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qb
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/tff_load_counter.sv
// rtl/tff_load_counter.sv - up/down/load counter whose state lives only in T flip-flops
import tff_load_counter_pkg::*;

module tff_load_counter #(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  tff_load_counter_if.slave bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] up_chain;
  logic [WIDTH-1:0] down_chain;
  logic             tc;
  logic             wrap;
  mode_e            mode;

  assign mode = mode_e'(bus.mode);

  // Bit i toggles when every lower bit is at its terminal value for the direction.
  always_comb begin
    up_chain      = '0;
    down_chain    = '0;
    up_chain[0]   = 1'b1;
    down_chain[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_chain[i]   = up_chain[i-1] & q[i-1];
      down_chain[i] = down_chain[i-1] & ~q[i-1];
    end
  end

  // Load toggles exactly the bits that differ, so a load of the current value is a no-op.
  always_comb begin
    t = '0;
    case (mode)
      MODE_HOLD: t = '0;
      MODE_UP:   t = up_chain;
      MODE_DOWN: t = down_chain;
      MODE_LOAD: t = bus.d ^ q;
      default:   t = '0;
    endcase
  end

  assign tc = ((mode == MODE_UP) && (&q)) || ((mode == MODE_DOWN) && ~(|q));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t[i]),
      .q   (q[i]),
      .qb  (qb[i])
    );
  end

  assign bus.q    = q;
  assign bus.qb   = qb;
  assign bus.tc   = tc;
  assign bus.wrap = wrap;

endmodule

// File: tb/tb_tff_load_counter.sv
// tb/tb_tff_load_counter.sv - randomized and directed bench for tff_load_counter against a modular-arithmetic model
import tff_load_counter_pkg::*;

module tb_tff_load_counter;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;

  tff_load_counter_if #(.WIDTH(W)) bus ();

  tff_load_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int mq        = 0;
  bit mw        = 1'b0;

  function automatic bit model_tc();
    return ((bus.mode == MODE_UP) && (mq == MAXV)) || ((bus.mode == MODE_DOWN) && (mq == 0));
  endfunction

  task automatic drive(input logic r, input logic [1:0] m, input logic [W-1:0] dd);
    rst      = r;
    bus.mode = m;
    bus.d    = dd;
    #1;
  endtask

  task automatic tick();
    bit tc_now;
    @(posedge clk);
    tc_now = model_tc();
    if (!rst) begin
      mq = 0;
      mw = 1'b0;
    end else begin
      case (bus.mode)
        MODE_UP:   mq = (mq + 1) % (MAXV + 1);
        MODE_DOWN: mq = (mq + MAXV) % (MAXV + 1);
        MODE_LOAD: mq = int'(bus.d);
        default:   mq = mq;
      endcase
      mw = tc_now;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b0, MODE_LOAD, 4'b1010);
    tick();
    tick();
    total_cnt++;
    if ({bus.q, bus.qb, bus.wrap} !== {4'b0000, 4'b1111, 1'b0})
      $display("FAIL reset_state q=%b qb=%b wrap=%b exp q=0000 qb=1111 wrap=0", bus.q, bus.qb, bus.wrap);
    else pass_cnt++;
    drive(1'b0, MODE_DOWN, 4'b0000);
    total_cnt++;
    if (bus.tc !== 1'b1) $display("FAIL reset_tc_down tc=%b exp 1", bus.tc);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_load_hold();
    drive(1'b1, MODE_LOAD, 4'b1101);
    tick();
    total_cnt++;
    if (bus.q !== 4'b1101) $display("FAIL load_q q=%b exp 1101", bus.q);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, MODE_HOLD, W'($urandom));
      tick();
      total_cnt++;
      if ({bus.q, bus.qb, bus.wrap} !== {4'b1101, 4'b0010, 1'b0})
        $display("FAIL hold_%0d q=%b qb=%b wrap=%b exp q=1101 qb=0010 wrap=0", i, bus.q, bus.qb, bus.wrap);
      else pass_cnt++;
    end
  endtask

  task automatic test_up_wrap();
    logic [W-1:0] exp_q [3];
    logic         exp_w [3];
    logic         exp_t [3];
    exp_q = '{4'b1111, 4'b0000, 4'b0001};
    exp_w = '{1'b0, 1'b1, 1'b0};
    exp_t = '{1'b0, 1'b1, 1'b0};
    drive(1'b1, MODE_LOAD, 4'b1110);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, MODE_UP, W'($urandom));
      total_cnt++;
      if (bus.tc !== exp_t[i]) $display("FAIL up_tc_%0d tc=%b exp %b", i, bus.tc, exp_t[i]);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({bus.q, bus.wrap} !== {exp_q[i], exp_w[i]})
        $display("FAIL up_step_%0d q=%b wrap=%b exp q=%b wrap=%b", i, bus.q, bus.wrap, exp_q[i], exp_w[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_down_wrap();
    drive(1'b1, MODE_LOAD, 4'b0001);
    tick();
    drive(1'b1, MODE_DOWN, 4'b0000);
    tick();
    total_cnt++;
    if ({bus.q, bus.tc, bus.wrap} !== {4'b0000, 1'b1, 1'b0})
      $display("FAIL down_zero q=%b tc=%b wrap=%b exp q=0000 tc=1 wrap=0", bus.q, bus.tc, bus.wrap);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.q, bus.wrap} !== {4'b1111, 1'b1})
      $display("FAIL down_wrap q=%b wrap=%b exp q=1111 wrap=1", bus.q, bus.wrap);
    else pass_cnt++;
    drive(1'b1, MODE_HOLD, 4'b0000);
    tick();
    total_cnt++;
    if ({bus.q, bus.wrap} !== {4'b1111, 1'b0})
      $display("FAIL down_wrap_end q=%b wrap=%b exp q=1111 wrap=0", bus.q, bus.wrap);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_count();
    drive(1'b1, MODE_LOAD, 4'b0101);
    tick();
    drive(1'b1, MODE_UP, 4'b0000);
    tick();
    tick();
    total_cnt++;
    if (bus.q !== 4'b0111) $display("FAIL mid_count q=%b exp 0111", bus.q);
    else pass_cnt++;
    drive(1'b0, MODE_UP, 4'b0000);
    tick();
    total_cnt++;
    if ({bus.q, bus.qb, bus.wrap} !== {4'b0000, 4'b1111, 1'b0})
      $display("FAIL mid_reset q=%b qb=%b wrap=%b exp q=0000 qb=1111 wrap=0", bus.q, bus.qb, bus.wrap);
    else pass_cnt++;
    drive(1'b1, MODE_UP, 4'b0000);
    tick();
    total_cnt++;
    if ({bus.q, bus.wrap} !== {4'b0001, 1'b0})
      $display("FAIL resume q=%b wrap=%b exp q=0001 wrap=0", bus.q, bus.wrap);
    else pass_cnt++;
  endtask

  task automatic test_reversal_and_noop_load();
    drive(1'b1, MODE_LOAD, 4'b1111);
    tick();
    drive(1'b1, MODE_DOWN, 4'b0000);
    total_cnt++;
    if (bus.tc !== 1'b0) $display("FAIL rev_tc tc=%b exp 0", bus.tc);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.q, bus.wrap} !== {4'b1110, 1'b0})
      $display("FAIL rev_step q=%b wrap=%b exp q=1110 wrap=0", bus.q, bus.wrap);
    else pass_cnt++;
    drive(1'b1, MODE_LOAD, 4'b1111);
    tick();
    drive(1'b1, MODE_LOAD, 4'b1111);
    tick();
    total_cnt++;
    if ({bus.q, bus.wrap} !== {4'b1111, 1'b0})
      $display("FAIL noop_load q=%b wrap=%b exp q=1111 wrap=0", bus.q, bus.wrap);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, MODE_UP, W'($urandom));
      total_cnt++;
      if (bus.tc !== 1'b1) $display("FAIL tc_vs_d_%0d d=%b tc=%b exp 1", i, bus.d, bus.tc);
      else pass_cnt++;
    end
    drive(1'b1, MODE_HOLD, 4'b0000);
    tick();
  endtask

  task automatic test_random();
    bit exp_tc;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 15) != 0), 2'($urandom), W'($urandom));
      exp_tc = model_tc();
      total_cnt++;
      if (bus.tc !== exp_tc) $display("FAIL rand_tc_%0d tc=%b exp %b", i, bus.tc, exp_tc);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({bus.q, bus.qb, bus.wrap} !== {W'(mq), ~W'(mq), mw})
        $display("FAIL rand_state_%0d q=%b qb=%b wrap=%b exp q=%b qb=%b wrap=%b",
                 i, bus.q, bus.qb, bus.wrap, W'(mq), ~W'(mq), mw);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst      = 1'b0;
    bus.mode = MODE_HOLD;
    bus.d    = '0;
    @(negedge clk);
    test_reset();
    test_load_hold();
    test_up_wrap();
    test_down_wrap();
    test_reset_mid_count();
    test_reversal_and_noop_load();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
